// File: rtl/neuron_pkg.sv
// Shared definitions for the neuron MAC stage: FSM state encoding, default bus
// widths and the accumulator width derivation.
package neuron_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Full product width plus enough headroom for n_inputs additions.
  function automatic int acc_width(input int data_w, input int n_inputs);
    return 2 * data_w + $clog2(n_inputs + 1);
  endfunction

endpackage

// File: rtl/neuron_mac_dp.sv
// Datapath for neuron_mac: unsigned multiplier, accumulator and step activation.
// The FSM supplies clear (start of evaluation), valid (product present) and capture.
module neuron_mac_dp
  import neuron_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ACC_W     = acc_width(DATA_W_DEF, 9),
  parameter int THRESHOLD = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              valid,
  input  logic              capture,
  input  logic [DATA_W-1:0] weight,
  input  logic [DATA_W-1:0] data,
  output logic [ACC_W-1:0]  acc_out,
  output logic              y
);

  logic [2*DATA_W-1:0] prod;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_d;
  logic [ACC_W-1:0]    acc_out_q;
  logic                y_q;

  // Operands widened first so the product is computed at full precision.
  assign prod = {{DATA_W{1'b0}}, weight} * {{DATA_W{1'b0}}, data};

  always_comb begin
    sum = acc_q;
    if (valid) begin
      sum = acc_q + ACC_W'(prod);
    end
  end

  always_comb begin
    acc_d = sum;
    if (clear) begin
      acc_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      acc_out_q <= '0;
      y_q       <= 1'b0;
    end else begin
      acc_q <= acc_d;
      if (capture) begin
        acc_out_q <= sum;
        y_q       <= (sum >= ACC_W'(THRESHOLD));
      end
    end
  end

  assign acc_out = acc_out_q;
  assign y       = y_q;

endmodule

// File: rtl/neuron_mac.sv
// Sequencing MAC stage: walks the weight ROM and input buffer in lockstep, feeds the
// datapath one product per cycle and hands the result downstream via valid/ready.
module neuron_mac
  import neuron_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int N_INPUTS    = 9,
  parameter int WEIGHT_BASE = 1,
  parameter int THRESHOLD   = 32,
  parameter int ACC_W       = acc_width(DATA_W, N_INPUTS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [ADDR_W-1:0] in_addr,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              y
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_INPUTS - 1);
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(WEIGHT_BASE);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic              out_valid_q, out_valid_d;
  logic              dvalid_q, dvalid_d;
  logic              clear;
  logic              capture;

  // Synchronous memories return data one cycle after the address, so the product
  // for an address issued in a RUN cycle arrives in the following cycle.
  assign dvalid_d = (state_q == ST_RUN);

  always_comb begin
    state_d     = state_q;
    rom_addr_d  = rom_addr_q;
    in_addr_d   = in_addr_q;
    out_valid_d = out_valid_q;
    clear       = 1'b0;
    capture     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clear      = 1'b1;
          rom_addr_d = BASE;
          in_addr_d  = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN: begin
        if (in_addr_q == LAST_IDX) begin
          state_d = ST_DRAIN;
        end else begin
          rom_addr_d = rom_addr_q + 1'b1;
          in_addr_d  = in_addr_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        capture     = 1'b1;
        out_valid_d = 1'b1;
        state_d     = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rom_addr_q  <= '0;
      in_addr_q   <= '0;
      out_valid_q <= 1'b0;
      dvalid_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rom_addr_q  <= rom_addr_d;
      in_addr_q   <= in_addr_d;
      out_valid_q <= out_valid_d;
      dvalid_q    <= dvalid_d;
    end
  end

  neuron_mac_dp #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .THRESHOLD(THRESHOLD)
  ) u_dp (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear),
    .valid  (dvalid_q),
    .capture(capture),
    .weight (rom_dout),
    .data   (in_data),
    .acc_out(acc_out),
    .y      (y)
  );

  assign busy      = (state_q != ST_IDLE);
  assign rom_addr  = rom_addr_q;
  assign in_addr   = in_addr_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Scoreboard bench for neuron_mac: directed evaluations push expected results,
// a negedge monitor pops and compares on every output handshake.
module tb_neuron_mac;

  localparam int ACC_W = 36;

  logic              clk;
  logic              rst;
  logic              start;
  logic              busy;
  logic [15:0]       rom_addr;
  logic [15:0]       rom_dout;
  logic [15:0]       in_addr;
  logic [15:0]       in_data;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              y;

  logic [15:0] rom_mem [0:15];
  logic [15:0] in_mem  [0:15];
  logic [15:0] w_def   [0:8];

  typedef struct {
    string            nm;
    logic [ACC_W-1:0] acc;
    logic             y;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks;
  int   n_errors;

  neuron_mac dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .busy     (busy),
    .rom_addr (rom_addr),
    .rom_dout (rom_dout),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .acc_out  (acc_out),
    .y        (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memory models: data one cycle after the address.
  always @(posedge clk) begin
    rom_dout <= rom_mem[rom_addr[3:0]];
    in_data  <= in_mem[in_addr[3:0]];
  end

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  // Monitor: one pop per accepted result.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_output: got acc_out=0x%0h y=%0b, expected no output", acc_out, y);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        $display("txn %s: acc_out=0x%0h y=%0b (expected 0x%0h/%0b)", e.nm, acc_out, y, e.acc, e.y);
        check({e.nm, "_acc"}, 64'(acc_out), 64'(e.acc));
        check({e.nm, "_y"}, 64'(y), 64'(e.y));
      end
    end
  end

  task automatic load_default_weights();
    rom_mem[0] = 16'hDEAD;
    for (int i = 0; i < 9; i++) rom_mem[i+1] = w_def[i];
    for (int i = 10; i < 16; i++) rom_mem[i] = 16'hBEEF;
  endtask

  task automatic set_inputs_const(input logic [15:0] v);
    for (int i = 0; i < 9; i++) in_mem[i] = v;
    for (int i = 9; i < 16; i++) in_mem[i] = 16'h7777;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for out_valid after the start edge; it must be visible in the 11th
  // cycle counted from the start edge, i.e. right after the 10th following edge.
  task automatic wait_valid(input string nm);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_latency"}, 64'(cyc), 64'd10);
  endtask

  task automatic wait_idle(input string nm);
    int cyc;
    cyc = 0;
    while (busy && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    check({nm, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_eval(input string nm, input logic [ACC_W-1:0] exp_acc, input logic exp_y);
    exp_t e;
    e.nm  = nm;
    e.acc = exp_acc;
    e.y   = exp_y;
    sb_q.push_back(e);
    pulse_start();
    check({nm, "_busy"}, 64'(busy), 64'd1);
    wait_valid(nm);
    wait_idle(nm);
  endtask

  initial begin
    exp_t e;
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b1;
    w_def[0] = 16'd1;  w_def[1] = 16'd3; w_def[2] = 16'd4;
    w_def[3] = 16'd5;  w_def[4] = 16'd6; w_def[5] = 16'd8;
    w_def[6] = 16'd9;  w_def[7] = 16'd10; w_def[8] = 16'd11;
    load_default_weights();
    set_inputs_const(16'd1);

    #12;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_rom_addr", 64'(rom_addr), 64'd0);
    check("rst_in_addr", 64'(in_addr), 64'd0);
    check("rst_acc_out", 64'(acc_out), 64'd0);
    check("rst_y", 64'(y), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_eval("ones", 36'd57, 1'b1);

    set_inputs_const(16'd0);
    run_eval("zeros", 36'd0, 1'b0);

    for (int i = 0; i < 9; i++) in_mem[i] = 16'(i);
    run_eval("ramp", 36'd302, 1'b1);

    // 2*11 + 1*10 = 32 sits exactly on the threshold.
    set_inputs_const(16'd0);
    in_mem[8] = 16'd2;
    in_mem[7] = 16'd1;
    run_eval("thr_eq", 36'd32, 1'b1);

    // 2*11 + 1*9 = 31, one below.
    in_mem[7] = 16'd0;
    in_mem[6] = 16'd1;
    run_eval("thr_below", 36'd31, 1'b0);

    for (int i = 1; i < 10; i++) rom_mem[i] = 16'hFFFF;
    set_inputs_const(16'hFFFF);
    run_eval("width", 36'h8FFEE0009, 1'b1);

    // Backpressure: result must hold while out_ready is low; a start in DONE is dropped.
    load_default_weights();
    set_inputs_const(16'd1);
    out_ready = 1'b0;
    e.nm  = "backpressure";
    e.acc = 36'd57;
    e.y   = 1'b1;
    sb_q.push_back(e);
    pulse_start();
    wait_valid("bp");
    for (int i = 0; i < 5; i++) begin
      start = (i == 1);
      @(posedge clk);
      #1;
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_acc", 64'(acc_out), 64'd57);
      check("bp_hold_y", 64'(y), 64'd1);
      check("bp_hold_busy", 64'(busy), 64'd1);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_after_valid", 64'(out_valid), 64'd0);
    check("bp_after_busy", 64'(busy), 64'd0);
    check("bp_retain_acc", 64'(acc_out), 64'd57);
    check("bp_retain_y", 64'(y), 64'd1);
    @(posedge clk);
    #1;
    check("bp_start_dropped", 64'(busy), 64'd0);

    // Reset in the 4th RUN cycle (between the 3rd and 4th edges after start).
    pulse_start();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_rom_addr", 64'(rom_addr), 64'd0);
    check("mid_rst_in_addr", 64'(in_addr), 64'd0);
    check("mid_rst_acc_out", 64'(acc_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_eval("after_rst", 36'd57, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
